// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, synchronous-read memory between the fetch port (I,
// read-only) and the execute load/store port (D). One access is issued per
// cycle. D normally wins. I is forced through after it has lost STARVE_MAX
// cycles in a row. Read data comes back one cycle after the grant, together
// with a valid strobe for the port that owns the read.
module mem_port_arbiter #(
    parameter int ADDR       = 32,
    parameter int WORD       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    // fetch port
    input  logic            i_req,
    input  logic [ADDR-1:0] i_addr,
    input  logic            i_flush,
    output logic            i_gnt,
    output logic            i_stall,
    output logic            i_rvalid,
    output logic [WORD-1:0] i_rdata,
    // load/store port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ADDR-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_stall,
    output logic            d_rvalid,
    output logic [WORD-1:0] d_rdata,
    // memory side
    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q
);

    // Counter must be able to hold STARVE_MAX itself.
    localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t          owner_reg;
    logic [CW-1:0]   starve_cnt_reg;
    logic            force_i;
    logic            d_win;

    // Grant decision: D has priority unless fetch has starved long enough.
    // Both grants are held low while reset is asserted.
    always_comb begin
        force_i = i_req && (starve_cnt_reg == CW'(STARVE_MAX));
        d_win   = d_req && !force_i;
        d_gnt   = !reset && d_win;
        i_gnt   = !reset && i_req && !d_win;
    end

    assign i_stall = i_req & ~i_gnt;
    assign d_stall = d_req & ~d_gnt;

    // Memory bus follows the granted port; idle bus is driven to zero.
    always_comb begin
        mem_a = '0;
        mem_w = 1'b0;
        mem_d = '0;
        if (d_gnt) begin
            mem_a = d_addr;
            mem_w = d_we;
            mem_d = d_wdata;
        end else if (i_gnt) begin
            mem_a = i_addr;
        end
    end

    // Read data is shared. Only the port whose rvalid is high should consume it.
    // A flush in the return cycle cancels the fetch strobe. The data itself
    // passes through unchanged.
    assign i_rdata  = mem_q;
    assign d_rdata  = mem_q;
    assign i_rvalid = (owner_reg == OWN_I) && !i_flush;
    assign d_rvalid = (owner_reg == OWN_D);

    // Owner of the read in flight, reloaded every cycle so back-to-back grants
    // give back-to-back strobes. Writes and idle cycles leave no owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_reg <= OWN_NONE;
        end else if (i_gnt) begin
            owner_reg <= OWN_I;
        end else if (d_gnt && !d_we) begin
            owner_reg <= OWN_D;
        end else begin
            owner_reg <= OWN_NONE;
        end
    end

    // Count consecutive lost fetch cycles, saturating at STARVE_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else if (i_req && !i_gnt) begin
            if (starve_cnt_reg != CW'(STARVE_MAX)) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end else begin
            starve_cnt_reg <= '0;
        end
    end

endmodule
